// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: byte/half/word accesses over a req/ack data bus.
// Define MEM_ALIGN_CHECK_EN to trap misaligned halfword/word accesses.
module mem_lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_wreg,
  input  logic [4:0]        ex_waddr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic              ex_whilo,
  input  logic [DATA_W-1:0] ex_hi,
  input  logic [DATA_W-1:0] ex_lo,
  input  logic [7:0]        ex_aluop,
  input  logic [31:0]       ex_mem_addr,
  input  logic [DATA_W-1:0] ex_reg2,
  input  logic              mem_stall,
  output logic              mem_wreg,
  output logic [4:0]        mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_whilo,
  output logic [DATA_W-1:0] mem_hi,
  output logic [DATA_W-1:0] mem_lo,
  output logic              stallreq,
  output logic              dbus_req,
  output logic              dbus_we,
  output logic [ADDR_W-1:0] dbus_addr,
  output logic [3:0]        dbus_sel,
  output logic [DATA_W-1:0] dbus_wdata,
  input  logic              dbus_ack,
  input  logic [DATA_W-1:0] dbus_rdata,
  output logic              excp_misalign
);

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  localparam logic [4:0] NOP_REG_ADDR = 5'b00000;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        sel_q, sel_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic op_lb, op_lbu, op_lh, op_lhu, op_lw;
  logic op_sb, op_sh, op_sw;
  logic is_load, is_store, is_mem;
  logic [1:0] boff;

  assign op_lb  = ex_aluop == EXE_LB_OP;
  assign op_lbu = ex_aluop == EXE_LBU_OP;
  assign op_lh  = ex_aluop == EXE_LH_OP;
  assign op_lhu = ex_aluop == EXE_LHU_OP;
  assign op_lw  = ex_aluop == EXE_LW_OP;
  assign op_sb  = ex_aluop == EXE_SB_OP;
  assign op_sh  = ex_aluop == EXE_SH_OP;
  assign op_sw  = ex_aluop == EXE_SW_OP;

  assign is_load  = op_lb | op_lbu | op_lh | op_lhu | op_lw;
  assign is_store = op_sb | op_sh | op_sw;
  assign is_mem   = is_load | is_store;
  assign boff     = ex_mem_addr[1:0];

  logic misaligned;
`ifdef MEM_ALIGN_CHECK_EN
  logic mis_q, mis_d;
  assign misaligned =
    ((op_lh | op_lhu | op_sh) & ex_mem_addr[0]) |
    ((op_lw | op_sw) & (|ex_mem_addr[1:0]));
  assign mis_d = (state_q == S_IDLE) ? (is_mem & misaligned) : mis_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mis_q <= 1'b0;
    else      mis_q <= mis_d;
  end

  assign excp_misalign = rst & (state_q == S_DONE) & mis_q;
`else
  assign misaligned    = 1'b0;
  assign excp_misalign = 1'b0;
`endif

  // Halfword lane follows addr[1] only, so addr[0] is ignored.
  logic [3:0]        sel_c;
  logic [DATA_W-1:0] wdata_c;
  always_comb begin
    sel_c   = 4'b1111;
    wdata_c = ex_reg2;
    unique case (1'b1)
      op_lb, op_lbu, op_sb: sel_c = 4'b1000 >> boff;
      op_lh, op_lhu, op_sh: sel_c = boff[1] ? 4'b0011 : 4'b1100;
      default: sel_c = 4'b1111;
    endcase
    unique case (1'b1)
      op_sb:   wdata_c = {4{ex_reg2[7:0]}};
      op_sh:   wdata_c = {2{ex_reg2[15:0]}};
      default: wdata_c = ex_reg2;
    endcase
  end

  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_data;
  always_comb begin
    unique case (boff)
      2'd0:    ld_byte = rdata_q[31:24];
      2'd1:    ld_byte = rdata_q[23:16];
      2'd2:    ld_byte = rdata_q[15:8];
      default: ld_byte = rdata_q[7:0];
    endcase
    ld_half = boff[1] ? rdata_q[15:0] : rdata_q[31:16];
    unique case (1'b1)
      op_lb:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      op_lbu:  ld_data = {24'b0, ld_byte};
      op_lh:   ld_data = {{16{ld_half[15]}}, ld_half};
      op_lhu:  ld_data = {16'b0, ld_half};
      default: ld_data = rdata_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (is_mem && misaligned) begin
          state_d = S_DONE;
        end else if (is_mem) begin
          state_d = S_BUSY;
          req_d   = 1'b1;
          we_d    = is_store;
          addr_d  = {ex_mem_addr[ADDR_W-1:2], 2'b00};
          sel_d   = sel_c;
          wdata_d = wdata_c;
        end
      end
      S_BUSY: begin
        if (dbus_ack) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          if (is_load) rdata_d = dbus_rdata;
        end
      end
      S_DONE: begin
        if (!mem_stall) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      sel_q   <= 4'b0000;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign dbus_req   = req_q;
  assign dbus_we    = we_q;
  assign dbus_addr  = addr_q;
  assign dbus_sel   = sel_q;
  assign dbus_wdata = wdata_q;

  always_comb begin
    mem_wreg  = ex_wreg;
    mem_waddr = ex_waddr;
    mem_wdata = ex_wdata;
    mem_whilo = ex_whilo;
    mem_hi    = ex_hi;
    mem_lo    = ex_lo;
    stallreq  = 1'b0;
    unique case (state_q)
      S_IDLE: stallreq = is_mem;
      S_BUSY: stallreq = 1'b1;
      S_DONE: begin
        if (is_load) mem_wdata = ld_data;
`ifdef MEM_ALIGN_CHECK_EN
        if (mis_q) mem_wreg = 1'b0;
`endif
      end
      default: stallreq = 1'b0;
    endcase
    // Outputs are forced quiet while reset is held, whatever ex_* shows.
    if (!rst) begin
      mem_wreg  = 1'b0;
      mem_waddr = NOP_REG_ADDR;
      mem_wdata = '0;
      mem_whilo = 1'b0;
      mem_hi    = '0;
      mem_lo    = '0;
      stallreq  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: directed load/store/pass-through vectors,
// a bus responder with programmable ack latency, and a mid-access reset.
module tb_mem_lsu;

  localparam logic [7:0] OP_ADDU = 8'b0010_0001;
  localparam logic [7:0] OP_LB   = 8'b1110_0000;
  localparam logic [7:0] OP_LH   = 8'b1110_0001;
  localparam logic [7:0] OP_LW   = 8'b1110_0011;
  localparam logic [7:0] OP_LBU  = 8'b1110_0100;
  localparam logic [7:0] OP_LHU  = 8'b1110_0101;
  localparam logic [7:0] OP_SB   = 8'b1110_1000;
  localparam logic [7:0] OP_SH   = 8'b1110_1001;
  localparam logic [7:0] OP_SW   = 8'b1110_1011;

  logic        clk, rst;
  logic        ex_wreg, ex_whilo, mem_stall;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_wdata, ex_hi, ex_lo, ex_mem_addr, ex_reg2;
  logic [7:0]  ex_aluop;
  logic        mem_wreg, mem_whilo, stallreq;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata, mem_hi, mem_lo;
  logic        dbus_req, dbus_we, dbus_ack, excp_misalign;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_sel;

  mem_lsu dut (
    .clk(clk), .rst(rst),
    .ex_wreg(ex_wreg), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
    .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
    .mem_stall(mem_stall),
    .mem_wreg(mem_wreg), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .stallreq(stallreq),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_sel(dbus_sel), .dbus_wdata(dbus_wdata),
    .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
    .excp_misalign(excp_misalign)
  );

  typedef struct {
    logic [7:0]  op;
    logic        wreg;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi, lo;
    logic [31:0] addr, reg2, rdata;
    int          ack_wait, hold;
    logic [31:0] exp_wdata;
    bit          chk_wdata;
    int          exp_stall;
    logic        exp_wreg, exp_excp;
    bit          bus, bwe;
    logic [31:0] baddr;
    logic [3:0]  bsel;
    logic [31:0] bwdata;
    bit          chk_bw;
  } vec_t;

  vec_t exp_q[$];
  vec_t bus_q[$];
  vec_t tv[$];

  int n_chk, n_fail;
  int ack_wait, wait_cnt;
  logic [31:0] rd_val;
  bit ex_valid;

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic vec_t mk(
    logic [7:0] op, logic wreg, logic [4:0] waddr, logic [31:0] wdata,
    logic [31:0] addr, logic [31:0] reg2, logic [31:0] rdata,
    int ack_w, int hold, logic [31:0] exp_wdata, bit chk_wd,
    int exp_stall, bit bus, bit bwe, logic [31:0] baddr,
    logic [3:0] bsel, logic [31:0] bwdata, bit chk_bw);
    vec_t v;
    v.op = op; v.wreg = wreg; v.waddr = waddr; v.wdata = wdata;
    v.whilo = 1'b0; v.hi = 32'h0; v.lo = 32'h0;
    v.addr = addr; v.reg2 = reg2; v.rdata = rdata;
    v.ack_wait = ack_w; v.hold = hold;
    v.exp_wdata = exp_wdata; v.chk_wdata = chk_wd;
    v.exp_stall = exp_stall; v.exp_wreg = wreg; v.exp_excp = 1'b0;
    v.bus = bus; v.bwe = bwe; v.baddr = baddr; v.bsel = bsel;
    v.bwdata = bwdata; v.chk_bw = chk_bw;
    return v;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bus responder: acks after ack_wait idle cycles of an asserted request.
  initial begin
    dbus_ack = 1'b0;
    dbus_rdata = 32'h0;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      dbus_ack = 1'b0;
      if (dbus_req && rst) begin
        if (wait_cnt >= ack_wait) begin
          dbus_ack = 1'b1;
          dbus_rdata = rd_val;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Commit monitor: the write-back bundle is taken on the edge after this.
  initial begin
    vec_t v;
    forever begin
      @(negedge clk);
      if (rst && ex_valid && !stallreq && !mem_stall) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_commit: got commit expected none");
        end else begin
          v = exp_q.pop_front();
          chk("mem_wreg", {31'b0, mem_wreg}, {31'b0, v.exp_wreg});
          chk("mem_waddr", {27'b0, mem_waddr}, {27'b0, v.waddr});
          if (v.chk_wdata) chk("mem_wdata", mem_wdata, v.exp_wdata);
          chk("mem_whilo", {31'b0, mem_whilo}, {31'b0, v.whilo});
          chk("mem_hi", mem_hi, v.hi);
          chk("mem_lo", mem_lo, v.lo);
          chk("excp_misalign", {31'b0, excp_misalign}, {31'b0, v.exp_excp});
        end
      end
    end
  end

  // Bus monitor: checks each new request and its stability until ack.
  initial begin
    vec_t b;
    logic prev_req;
    logic [31:0] s_addr, s_wdata;
    logic [3:0] s_sel;
    logic s_we;
    prev_req = 1'b0;
    s_addr = 0; s_wdata = 0; s_sel = 0; s_we = 0;
    forever begin
      @(negedge clk);
      if (dbus_req && !prev_req) begin
        if (bus_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_bus_req: dbus_req got 1 expected 0");
        end else begin
          b = bus_q.pop_front();
          chk("bus_we", {31'b0, dbus_we}, {31'b0, b.bwe});
          chk("bus_addr", dbus_addr, b.baddr);
          chk("bus_sel", {28'b0, dbus_sel}, {28'b0, b.bsel});
          if (b.chk_bw) chk("bus_wdata", dbus_wdata, b.bwdata);
        end
        s_addr = dbus_addr; s_wdata = dbus_wdata;
        s_sel = dbus_sel; s_we = dbus_we;
      end else if (dbus_req) begin
        chk("bus_addr_stable", dbus_addr, s_addr);
        chk("bus_sel_stable", {28'b0, dbus_sel}, {28'b0, s_sel});
        chk("bus_wdata_stable", dbus_wdata, s_wdata);
        chk("bus_we_stable", {31'b0, dbus_we}, {31'b0, s_we});
      end
      prev_req = dbus_req;
    end
  end

  task automatic set_nop();
    ex_valid = 1'b0;
    ex_aluop = 8'h00; ex_wreg = 1'b0; ex_waddr = 5'd0;
    ex_wdata = 32'h0; ex_whilo = 1'b0; ex_hi = 32'h0; ex_lo = 32'h0;
    ex_mem_addr = 32'h0; ex_reg2 = 32'h0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the commit edge.
  task automatic run_vec(input vec_t v);
    int stalls, hold, cyc;
    bit done;
    stalls = 0; hold = v.hold; cyc = 0; done = 0;
    ack_wait = v.ack_wait; rd_val = v.rdata;
    ex_aluop = v.op; ex_wreg = v.wreg; ex_waddr = v.waddr;
    ex_wdata = v.wdata; ex_whilo = v.whilo; ex_hi = v.hi; ex_lo = v.lo;
    ex_mem_addr = v.addr; ex_reg2 = v.reg2;
    mem_stall = (hold > 0);
    exp_q.push_back(v);
    if (v.bus) bus_q.push_back(v);
    ex_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (stallreq) begin
        stalls++;
      end else if (hold > 0) begin
        if (v.chk_wdata) chk("hold_wdata", mem_wdata, v.exp_wdata);
        chk("hold_no_req", {31'b0, dbus_req}, 32'h0);
        hold--;
      end else begin
        done = 1;
      end
      if (!done && cyc > 60) begin
        n_chk++; n_fail++;
        $display("FAIL commit_timeout: op %h got no commit in 60 cycles",
                 v.op);
        done = 1;
      end
      @(posedge clk); #1;
      if (hold == 0) mem_stall = 1'b0;
    end
    chk("stall_cycles", stalls, v.exp_stall);
    set_nop();
  endtask

  task automatic reset_test();
    vec_t b;
    int cyc;
    b = mk(OP_LW, 1, 3, 0, 32'h8004, 0, 0, 0, 0, 0, 0, 0,
           1, 0, 32'h8004, 4'b1111, 0, 0);
    ack_wait = 1000;
    bus_q.push_back(b);
    ex_aluop = OP_LW; ex_wreg = 1'b1; ex_waddr = 5'd3;
    ex_mem_addr = 32'h8004;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!dbus_req && cyc < 10);
    chk("rst_pre_req", {31'b0, dbus_req}, 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("rst_async_req", {31'b0, dbus_req}, 32'h0);
    chk("rst_stallreq", {31'b0, stallreq}, 32'h0);
    chk("rst_waddr", {27'b0, mem_waddr}, 32'h0);
    chk("rst_wreg", {31'b0, mem_wreg}, 32'h0);
    chk("rst_addr", dbus_addr, 32'h0);
    set_nop();
    @(posedge clk); #3 rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_req", {31'b0, dbus_req}, 32'h0);
      chk("post_rst_stall", {31'b0, stallreq}, 32'h0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t v;
    n_chk = 0; n_fail = 0;
    ack_wait = 0; rd_val = 32'h0;
    mem_stall = 1'b0;
    rst = 1'b0;
    set_nop();
    ex_aluop = OP_LW; ex_wreg = 1'b1; ex_waddr = 5'h1f;
    ex_wdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    chk("reset_req", {31'b0, dbus_req}, 32'h0);
    chk("reset_we", {31'b0, dbus_we}, 32'h0);
    chk("reset_addr", dbus_addr, 32'h0);
    chk("reset_sel", {28'b0, dbus_sel}, 32'h0);
    chk("reset_bwdata", dbus_wdata, 32'h0);
    chk("reset_stallreq", {31'b0, stallreq}, 32'h0);
    chk("reset_wreg", {31'b0, mem_wreg}, 32'h0);
    chk("reset_waddr", {27'b0, mem_waddr}, 32'h0);
    chk("reset_wdata", mem_wdata, 32'h0);
    chk("reset_excp", {31'b0, excp_misalign}, 32'h0);
    set_nop();
    @(posedge clk); #1 rst = 1'b1;

    v = mk(OP_ADDU, 1, 5, 32'h1234_5678, 0, 0, 0, 0, 0,
           32'h1234_5678, 1, 0, 0, 0, 0, 0, 0, 0);
    v.whilo = 1'b1; v.hi = 32'hA5A5_0001; v.lo = 32'h5A5A_0002;
    tv.push_back(v);
    tv.push_back(mk(OP_LB, 1, 7, 0, 32'h1001, 0, 32'hAA80_CCDD, 2, 0,
                    32'hFFFF_FF80, 1, 4, 1, 0, 32'h1000, 4'b0100, 0, 0));
    tv.push_back(mk(OP_LBU, 1, 8, 0, 32'h1001, 0, 32'hAA80_CCDD, 2, 0,
                    32'h0000_0080, 1, 4, 1, 0, 32'h1000, 4'b0100, 0, 0));
    tv.push_back(mk(OP_SH, 0, 0, 32'h2002, 32'h2002, 32'h0000_BEEF, 0, 0,
                    0, 32'h2002, 1, 2, 1, 1, 32'h2000, 4'b0011,
                    32'hBEEF_BEEF, 1));
    tv.push_back(mk(OP_LW, 1, 9, 0, 32'h4000, 0, 32'hCAFE_F00D, 0, 2,
                    32'hCAFE_F00D, 1, 2, 1, 0, 32'h4000, 4'b1111, 0, 0));
    tv.push_back(mk(OP_SB, 0, 0, 32'h55, 32'h5003, 32'h1234_56A5, 0, 1, 0,
                    32'h55, 1, 3, 1, 1, 32'h5000, 4'b0001,
                    32'hA5A5_A5A5, 1));
    tv.push_back(mk(OP_LH, 1, 10, 0, 32'h6002, 0, 32'h1234_F00D, 0, 0,
                    32'hFFFF_F00D, 1, 2, 1, 0, 32'h6000, 4'b0011, 0, 0));
    tv.push_back(mk(OP_LHU, 1, 12, 0, 32'h6000, 0, 32'h8001_7777, 1, 0,
                    32'h0000_8001, 1, 3, 1, 0, 32'h6000, 4'b1100, 0, 0));
    tv.push_back(mk(OP_SW, 0, 0, 32'h7000, 32'h7000, 32'hDEAD_BEEF, 0, 0,
                    0, 32'h7000, 1, 2, 1, 1, 32'h7000, 4'b1111,
                    32'hDEAD_BEEF, 1));
`ifdef MEM_ALIGN_CHECK_EN
    v = mk(OP_LW, 1, 11, 0, 32'h3002, 0, 32'h1122_3344, 0, 0,
           0, 0, 1, 0, 0, 0, 0, 0, 0);
    v.exp_wreg = 1'b0; v.exp_excp = 1'b1;
    tv.push_back(v);
`else
    tv.push_back(mk(OP_LW, 1, 11, 0, 32'h3002, 0, 32'h1122_3344, 0, 0,
                    32'h1122_3344, 1, 2, 1, 0, 32'h3000, 4'b1111, 0, 0));
`endif
    tv.push_back(mk(OP_LB, 1, 13, 0, 32'h1000, 0, 32'h7F00_0000, 0, 0,
                    32'h0000_007F, 1, 2, 1, 0, 32'h1000, 4'b1000, 0, 0));

    for (int i = 0; i < tv.size(); i++) begin
      if (i == 5) reset_test();
      run_vec(tv[i]);
    end

    repeat (3) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 32'h0);
    chk("bus_q_drained", bus_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
